// File: rtl/rs_dispatch.sv
// Reservation-station dispatch block. It holds NUM_RS instruction entries,
// wakes up waiting operands from the CDB (including a bypass at allocation),
// and dispatches the lowest-index READY entry through a registered strobe.
//
// Handshake: alloc_ready is high whenever some entry is FREE. An allocation
// happens on any edge where alloc_valid && alloc_ready. Dispatch happens on
// any edge where exec_ready is high and a READY entry exists. exec_b is a
// one-cycle registered pulse per dispatch, and exec_done later returns the
// entry index. No input is required to stay stable while waiting.
module rs_dispatch #(
    parameter int NUM_RS = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [3:0]        alloc_func,
    input  logic [3:0]        alloc_rd,
    input  logic [2:0]        alloc_rob,
    input  logic              alloc_s1_rdy,
    input  logic              alloc_s2_rdy,
    input  logic [DATA_W-1:0] alloc_s1_data,
    input  logic [DATA_W-1:0] alloc_s2_data,
    input  logic [2:0]        alloc_s1_tag,
    input  logic [2:0]        alloc_s2_tag,
    input  logic              cdb_valid,
    input  logic [2:0]        cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              exec_ready,
    input  logic              exec_done,
    input  logic [2:0]        done_index,
    input  logic              flush,
    output logic              exec_b,
    output logic [2:0]        rs_index,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [3:0]        func,
    output logic [2:0]        rob_ind,
    output logic [3:0]        rd
);

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;
    localparam logic [1:0] ST_ISSUED = 2'd3;

    logic [1:0]        r_state     [NUM_RS];
    logic [1:0]        w_state_nxt [NUM_RS];
    logic [3:0]        r_func      [NUM_RS];
    logic [3:0]        r_rd        [NUM_RS];
    logic [2:0]        r_rob       [NUM_RS];
    logic              r_v1        [NUM_RS];
    logic              r_v2        [NUM_RS];
    logic [2:0]        r_t1        [NUM_RS];
    logic [2:0]        r_t2        [NUM_RS];
    logic [DATA_W-1:0] r_d1        [NUM_RS];
    logic [DATA_W-1:0] r_d2        [NUM_RS];

    logic              r_exec_b;
    logic [2:0]        r_rs_index;
    logic [DATA_W-1:0] r_rs1_data;
    logic [DATA_W-1:0] r_rs2_data;
    logic [3:0]        r_func_o;
    logic [2:0]        r_rob_o;
    logic [3:0]        r_rd_o;

    logic              w_any_free;
    logic [2:0]        w_free_idx;
    logic              w_any_ready;
    logic [2:0]        w_sel_idx;
    logic              w_alloc_fire;
    logic              w_disp;
    logic              w_a_v1;
    logic              w_a_v2;
    logic [DATA_W-1:0] w_a_d1;
    logic [DATA_W-1:0] w_a_d2;
    logic [DATA_W-1:0] w_sel_d1;
    logic [DATA_W-1:0] w_sel_d2;
    logic [3:0]        w_sel_func;
    logic [2:0]        w_sel_rob;
    logic [3:0]        w_sel_rd;

    // Lowest-index FREE entry (allocation target) and lowest-index READY entry (dispatch pick).
    always_comb begin
        w_any_free  = 1'b0;
        w_free_idx  = '0;
        w_any_ready = 1'b0;
        w_sel_idx   = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (r_state[i] == ST_FREE) begin
                w_any_free = 1'b1;
                w_free_idx = 3'(i);
            end
            if (r_state[i] == ST_READY) begin
                w_any_ready = 1'b1;
                w_sel_idx   = 3'(i);
            end
        end
    end

    assign alloc_ready  = w_any_free;
    assign w_alloc_fire = alloc_valid && w_any_free && !flush;
    assign w_disp       = exec_ready && w_any_ready && !flush;

    // An operand that is not ready at allocation can still be caught off the CDB in the same cycle.
    assign w_a_v1 = alloc_s1_rdy || (cdb_valid && (cdb_tag == alloc_s1_tag));
    assign w_a_v2 = alloc_s2_rdy || (cdb_valid && (cdb_tag == alloc_s2_tag));
    assign w_a_d1 = alloc_s1_rdy ? alloc_s1_data : cdb_data;
    assign w_a_d2 = alloc_s2_rdy ? alloc_s2_data : cdb_data;

    // Entry state register; reset discards every entry, including ISSUED ones.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RS; i++) r_state[i] <= ST_FREE;
        end else begin
            for (int i = 0; i < NUM_RS; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    // Per-entry next state. WAIT goes READY one cycle after its operands are complete, which
    // keeps a wakeup from dispatching in the same cycle. A done_index past the last entry matches nothing.
    always_comb begin
        for (int i = 0; i < NUM_RS; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                ST_FREE:   if (w_alloc_fire && (w_free_idx == 3'(i)))
                               w_state_nxt[i] = (w_a_v1 && w_a_v2) ? ST_READY : ST_WAIT;
                ST_WAIT:   if (r_v1[i] && r_v2[i]) w_state_nxt[i] = ST_READY;
                ST_READY:  if (w_disp && (w_sel_idx == 3'(i))) w_state_nxt[i] = ST_ISSUED;
                ST_ISSUED: if (exec_done && (done_index == 3'(i))) w_state_nxt[i] = ST_FREE;
                default:   w_state_nxt[i] = ST_FREE;
            endcase
            if (flush) w_state_nxt[i] = ST_FREE;
        end
    end

    // Entry payload: written at allocation, operands captured off the CDB while WAIT.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RS; i++) begin
                r_func[i] <= '0;
                r_rd[i]   <= '0;
                r_rob[i]  <= '0;
                r_v1[i]   <= 1'b0;
                r_v2[i]   <= 1'b0;
                r_t1[i]   <= '0;
                r_t2[i]   <= '0;
                r_d1[i]   <= '0;
                r_d2[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (flush) begin
                    r_v1[i] <= 1'b0;
                    r_v2[i] <= 1'b0;
                end else if (w_alloc_fire && (w_free_idx == 3'(i))) begin
                    r_func[i] <= alloc_func;
                    r_rd[i]   <= alloc_rd;
                    r_rob[i]  <= alloc_rob;
                    r_v1[i]   <= w_a_v1;
                    r_v2[i]   <= w_a_v2;
                    r_t1[i]   <= alloc_s1_tag;
                    r_t2[i]   <= alloc_s2_tag;
                    r_d1[i]   <= w_a_d1;
                    r_d2[i]   <= w_a_d2;
                end else if (cdb_valid && (r_state[i] == ST_WAIT)) begin
                    if (!r_v1[i] && (r_t1[i] == cdb_tag)) begin
                        r_v1[i] <= 1'b1;
                        r_d1[i] <= cdb_data;
                    end
                    if (!r_v2[i] && (r_t2[i] == cdb_tag)) begin
                        r_v2[i] <= 1'b1;
                        r_d2[i] <= cdb_data;
                    end
                end
            end
        end
    end

    // Output comb: payload mux of the entry picked for dispatch.
    always_comb begin
        w_sel_d1   = '0;
        w_sel_d2   = '0;
        w_sel_func = '0;
        w_sel_rob  = '0;
        w_sel_rd   = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (w_sel_idx == 3'(i)) begin
                w_sel_d1   = r_d1[i];
                w_sel_d2   = r_d2[i];
                w_sel_func = r_func[i];
                w_sel_rob  = r_rob[i];
                w_sel_rd   = r_rd[i];
            end
        end
    end

    // Dispatch register: one-cycle strobe, payload held between dispatches.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_exec_b   <= 1'b0;
            r_rs_index <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_func_o   <= '0;
            r_rob_o    <= '0;
            r_rd_o     <= '0;
        end else begin
            r_exec_b <= w_disp;
            if (w_disp) begin
                r_rs_index <= w_sel_idx;
                r_rs1_data <= w_sel_d1;
                r_rs2_data <= w_sel_d2;
                r_func_o   <= w_sel_func;
                r_rob_o    <= w_sel_rob;
                r_rd_o     <= w_sel_rd;
            end
        end
    end

    assign exec_b   = r_exec_b;
    assign rs_index = r_rs_index;
    assign rs1_data = r_rs1_data;
    assign rs2_data = r_rs2_data;
    assign func     = r_func_o;
    assign rob_ind  = r_rob_o;
    assign rd       = r_rd_o;

endmodule

// File: tb/tb_rs_dispatch.sv
// Bench for rs_dispatch: directed scenarios followed by random traffic. A
// timestamp-based model predicts each dispatch, and a monitor checks the DUT
// against the predicted dispatch queue.
module tb_rs_dispatch;

    localparam int NUM_RS = 3;
    localparam int DATA_W = 8;
    localparam int W      = 30;
    localparam int INF    = 1 << 30;

    logic              clk1;
    logic              rst_n;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [3:0]        alloc_func;
    logic [3:0]        alloc_rd;
    logic [2:0]        alloc_rob;
    logic              alloc_s1_rdy;
    logic              alloc_s2_rdy;
    logic [DATA_W-1:0] alloc_s1_data;
    logic [DATA_W-1:0] alloc_s2_data;
    logic [2:0]        alloc_s1_tag;
    logic [2:0]        alloc_s2_tag;
    logic              cdb_valid;
    logic [2:0]        cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              exec_ready;
    logic              exec_done;
    logic [2:0]        done_index;
    logic              flush;
    logic              exec_b;
    logic [2:0]        rs_index;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [3:0]        func;
    logic [2:0]        rob_ind;
    logic [3:0]        rd;

    rs_dispatch #(.NUM_RS(NUM_RS), .DATA_W(DATA_W)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_func(alloc_func), .alloc_rd(alloc_rd), .alloc_rob(alloc_rob),
        .alloc_s1_rdy(alloc_s1_rdy), .alloc_s2_rdy(alloc_s2_rdy),
        .alloc_s1_data(alloc_s1_data), .alloc_s2_data(alloc_s2_data),
        .alloc_s1_tag(alloc_s1_tag), .alloc_s2_tag(alloc_s2_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .exec_ready(exec_ready), .exec_done(exec_done), .done_index(done_index),
        .flush(flush), .exec_b(exec_b), .rs_index(rs_index),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .func(func),
        .rob_ind(rob_ind), .rd(rd)
    );

    // Clock
    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_last = '0;

    // Reference model: each busy entry carries the edge number from which it may dispatch.
    bit          m_busy [NUM_RS];
    bit          m_iss  [NUM_RS];
    bit          m_k1   [NUM_RS];
    bit          m_k2   [NUM_RS];
    logic [7:0]  m_d1   [NUM_RS];
    logic [7:0]  m_d2   [NUM_RS];
    logic [2:0]  m_t1   [NUM_RS];
    logic [2:0]  m_t2   [NUM_RS];
    logic [2:0]  m_rob  [NUM_RS];
    logic [3:0]  m_func [NUM_RS];
    logic [3:0]  m_rd   [NUM_RS];
    int          m_elig [NUM_RS];
    int          m_cyc = 0;

    function automatic bit m_has_free();
        for (int i = 0; i < NUM_RS; i++) if (!m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Model update at each edge from the inputs the DUT sees at that edge.
    always @(posedge clk1 or negedge rst_n) begin : mdl
        int  a_idx;
        int  s_idx;
        int  di;
        bit  d_ok;
        if (!rst_n) begin
            for (int i = 0; i < NUM_RS; i++) begin
                m_busy[i] = 1'b0;
                m_iss[i]  = 1'b0;
            end
            exp_q.delete();
            m_last = '0;
        end else begin
            m_cyc++;
            if (flush) begin
                for (int i = 0; i < NUM_RS; i++) begin
                    m_busy[i] = 1'b0;
                    m_iss[i]  = 1'b0;
                end
            end else begin
                a_idx = -1;
                for (int i = NUM_RS - 1; i >= 0; i--) if (!m_busy[i]) a_idx = i;
                s_idx = -1;
                if (exec_ready)
                    for (int i = NUM_RS - 1; i >= 0; i--)
                        if (m_busy[i] && !m_iss[i] && m_elig[i] <= m_cyc) s_idx = i;
                di   = int'(done_index);
                d_ok = exec_done && (di < NUM_RS) && m_iss[di % NUM_RS];
                if (s_idx >= 0) begin
                    exp_q.push_back({3'(s_idx), m_d1[s_idx], m_d2[s_idx], m_func[s_idx],
                                     m_rob[s_idx], m_rd[s_idx]});
                    m_iss[s_idx] = 1'b1;
                end
                if (d_ok) begin
                    m_busy[di] = 1'b0;
                    m_iss[di]  = 1'b0;
                end
                if (cdb_valid) begin
                    for (int i = 0; i < NUM_RS; i++) begin
                        if (m_busy[i] && !m_iss[i] && m_elig[i] == INF) begin
                            if (!m_k1[i] && m_t1[i] == cdb_tag) begin m_k1[i] = 1'b1; m_d1[i] = cdb_data; end
                            if (!m_k2[i] && m_t2[i] == cdb_tag) begin m_k2[i] = 1'b1; m_d2[i] = cdb_data; end
                            if (m_k1[i] && m_k2[i]) m_elig[i] = m_cyc + 2;
                        end
                    end
                end
                if (alloc_valid && a_idx >= 0) begin
                    m_busy[a_idx] = 1'b1;
                    m_iss[a_idx]  = 1'b0;
                    m_func[a_idx] = alloc_func;
                    m_rd[a_idx]   = alloc_rd;
                    m_rob[a_idx]  = alloc_rob;
                    m_t1[a_idx]   = alloc_s1_tag;
                    m_t2[a_idx]   = alloc_s2_tag;
                    m_k1[a_idx]   = alloc_s1_rdy || (cdb_valid && cdb_tag == alloc_s1_tag);
                    m_k2[a_idx]   = alloc_s2_rdy || (cdb_valid && cdb_tag == alloc_s2_tag);
                    m_d1[a_idx]   = alloc_s1_rdy ? alloc_s1_data : cdb_data;
                    m_d2[a_idx]   = alloc_s2_rdy ? alloc_s2_data : cdb_data;
                    m_elig[a_idx] = (m_k1[a_idx] && m_k2[a_idx]) ? m_cyc + 1 : INF;
                end
            end
        end
    end

    // Monitor / scoreboard: checks the strobe and the output payload every cycle.
    always @(posedge clk1) begin : mon
        logic [W-1:0] act;
        bit           exp_b;
        #1;
        act   = {rs_index, rs1_data, rs2_data, func, rob_ind, rd};
        exp_b = (exp_q.size() > 0);
        n_cmp++;
        if (exec_b !== exp_b) begin
            n_err++;
            $display("FAIL exec_b at %0t: got %b want %b", $time, exec_b, exp_b);
        end
        if (exp_b) m_last = exp_q.pop_front();
        n_cmp++;
        if (act !== m_last) begin
            n_err++;
            $display("FAIL dispatch_payload at %0t: got %h want %h", $time, act, m_last);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(negedge clk1);
        chk("alloc_ready", 32'(alloc_ready), 32'(m_has_free()));
        alloc_valid = 1'b0;
        cdb_valid   = 1'b0;
        exec_done   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic do_alloc(input logic [3:0] f, input logic [3:0] r, input logic [2:0] rob,
                            input logic v1, input logic [7:0] d1, input logic [2:0] t1,
                            input logic v2, input logic [7:0] d2, input logic [2:0] t2);
        alloc_valid   = 1'b1;
        alloc_func    = f;
        alloc_rd      = r;
        alloc_rob     = rob;
        alloc_s1_rdy  = v1;
        alloc_s1_data = d1;
        alloc_s1_tag  = t1;
        alloc_s2_rdy  = v2;
        alloc_s2_data = d2;
        alloc_s2_tag  = t2;
    endtask

    task automatic do_cdb(input logic [2:0] tag, input logic [7:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    task automatic do_done(input logic [2:0] idx);
        exec_done  = 1'b1;
        done_index = idx;
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_valid = 1'b0; alloc_func = '0; alloc_rd = '0; alloc_rob = '0;
        alloc_s1_rdy = 1'b0; alloc_s2_rdy = 1'b0; alloc_s1_data = '0; alloc_s2_data = '0;
        alloc_s1_tag = '0; alloc_s2_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        exec_ready = 1'b0; exec_done = 1'b0; done_index = '0; flush = 1'b0;
        repeat (3) step();
        chk("rst_exec_b", 32'(exec_b), 32'd0);
        chk("rst_rs_index", 32'(rs_index), 32'd0);
        chk("rst_rs1_data", 32'(rs1_data), 32'd0);
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Ready allocation dispatches two edges later
        exec_ready = 1'b1;
        do_alloc(4'd0, 4'd3, 3'd1, 1'b1, 8'd5, 3'd0, 1'b1, 8'd7, 3'd0);
        step();
        chk("ready_early", 32'(exec_b), 32'd0);
        step();
        chk("ready_exec_b", 32'(exec_b), 32'd1);
        chk("ready_rs_index", 32'(rs_index), 32'd0);
        chk("ready_rs1", 32'(rs1_data), 32'd5);
        chk("ready_rs2", 32'(rs2_data), 32'd7);
        chk("ready_rob", 32'(rob_ind), 32'd1);
        chk("ready_rd", 32'(rd), 32'd3);
        step();
        chk("ready_pulse", 32'(exec_b), 32'd0);
        do_done(3'd0);
        step();

        // Wakeup from CDB
        do_alloc(4'd1, 4'd2, 3'd5, 1'b0, 8'd0, 3'd2, 1'b1, 8'd4, 3'd0);
        step(); step(); step();
        chk("wake_wait", 32'(exec_b), 32'd0);
        do_cdb(3'd2, 8'd9);
        step();
        chk("wake_c0", 32'(exec_b), 32'd0);
        step();
        chk("wake_c1", 32'(exec_b), 32'd0);
        step();
        chk("wake_exec_b", 32'(exec_b), 32'd1);
        chk("wake_rs1", 32'(rs1_data), 32'd9);
        chk("wake_rs2", 32'(rs2_data), 32'd4);
        do_done(3'd0);
        step();

        // Fill all entries, then free entry 1
        exec_ready = 1'b0;
        do_alloc(4'd2, 4'd1, 3'd2, 1'b1, 8'h0a, 3'd0, 1'b1, 8'h0b, 3'd0); step();
        do_alloc(4'd3, 4'd2, 3'd3, 1'b1, 8'h1a, 3'd0, 1'b1, 8'h1b, 3'd0); step();
        do_alloc(4'd0, 4'd4, 3'd4, 1'b1, 8'h2a, 3'd0, 1'b1, 8'h2b, 3'd0); step();
        chk("full_ready", 32'(alloc_ready), 32'd0);
        do_alloc(4'd1, 4'd5, 3'd7, 1'b1, 8'hee, 3'd0, 1'b1, 8'hef, 3'd0); step();
        chk("full_ignored", 32'(alloc_ready), 32'd0);
        exec_ready = 1'b1;
        step(); step(); step();
        exec_ready = 1'b0;
        do_done(3'd1);
        step();
        chk("freed_ready", 32'(alloc_ready), 32'd1);
        do_alloc(4'd1, 4'd6, 3'd6, 1'b1, 8'h21, 3'd0, 1'b1, 8'h22, 3'd0);
        step();
        exec_ready = 1'b1;
        step();
        chk("refill_exec_b", 32'(exec_b), 32'd1);
        chk("refill_index", 32'(rs_index), 32'd1);
        flush = 1'b1;
        step(); step();

        // Bypass at allocation
        do_alloc(4'd2, 4'd7, 3'd3, 1'b1, 8'd3, 3'd0, 1'b0, 8'd0, 3'd4);
        do_cdb(3'd4, 8'h11);
        step(); step();
        chk("byp_exec_b", 32'(exec_b), 32'd1);
        chk("byp_rs1", 32'(rs1_data), 32'd3);
        chk("byp_rs2", 32'(rs2_data), 32'h11);
        flush = 1'b1;
        step();

        // Priority and backpressure
        exec_ready = 1'b0;
        do_alloc(4'd0, 4'd1, 3'd0, 1'b1, 8'h31, 3'd0, 1'b1, 8'h32, 3'd0); step();
        do_alloc(4'd1, 4'd2, 3'd1, 1'b0, 8'h00, 3'd6, 1'b1, 8'h42, 3'd0); step();
        do_alloc(4'd3, 4'd3, 3'd2, 1'b1, 8'h51, 3'd0, 1'b1, 8'h52, 3'd0); step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_no_exec", 32'(exec_b), 32'd0);
        end
        exec_ready = 1'b1;
        step();
        chk("prio_first_b", 32'(exec_b), 32'd1);
        chk("prio_first", 32'(rs_index), 32'd0);
        step();
        chk("prio_second_b", 32'(exec_b), 32'd1);
        chk("prio_second", 32'(rs_index), 32'd2);
        step();
        chk("prio_idle", 32'(exec_b), 32'd0);

        // Flush with WAIT and ISSUED entries, then stale CDB
        flush = 1'b1;
        step();
        chk("flush_exec_b", 32'(exec_b), 32'd0);
        chk("flush_alloc_ready", 32'(alloc_ready), 32'd1);
        do_cdb(3'd6, 8'h77);
        do_done(3'd0);
        step(); step(); step();

        // Reset while a dispatch strobe is high
        do_alloc(4'd2, 4'd9, 3'd3, 1'b1, 8'h61, 3'd0, 1'b1, 8'h62, 3'd0);
        step(); step();
        chk("pre_rst_exec_b", 32'(exec_b), 32'd1);
        rst_n = 1'b0;
        do_alloc(4'd2, 4'd9, 3'd3, 1'b1, 8'h71, 3'd0, 1'b1, 8'h72, 3'd0);
        do_cdb(3'd6, 8'h55);
        do_done(3'd0);
        #1;
        chk("rst_async_exec_b", 32'(exec_b), 32'd0);
        step(); step();
        chk("mid_rst_rs1", 32'(rs1_data), 32'd0);
        chk("mid_rst_alloc_ready", 32'(alloc_ready), 32'd1);
        rst_n = 1'b1;
        step(); step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            exec_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0)
                do_alloc(4'($urandom_range(0, 3)), 4'($urandom), 3'($urandom),
                         1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom),
                         1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom));
            if ($urandom_range(0, 2) == 0) do_cdb(3'($urandom), 8'($urandom));
            if ($urandom_range(0, 2) == 0) do_done(3'($urandom_range(0, 3)));
            if ($urandom_range(0, 60) == 0) flush = 1'b1;
        end

        exec_ready = 1'b0;
        repeat (5) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rs_dispatch.md
RS_DISPATCH -- requirements
Module: rs_dispatch

Interface
REQ-001 SHALL have parameter NUM_RS, default 3, number of reservation-station entries (index width 3 bits fixed).
REQ-002 SHALL have parameter DATA_W, default 8, operand and CDB data width.
REQ-003 SHALL have ports (one clock; reset is asynchronous and active-low):
- clk1  in  1  sole clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_valid  in  1  issue stage presents a new instruction.
- alloc_ready  out  1  a FREE entry exists (combinational).
- alloc_func  in  4  opcode (0000 add, 0001 sub, 0010 mul, 0011 div).
- alloc_rd  in  4  destination register.
- alloc_rob  in  3  ROB index of the instruction.
- alloc_s1_rdy / alloc_s2_rdy  in  1 each  operand value present.
- alloc_s1_data / alloc_s2_data  in  DATA_W each  operand value when ready.
- alloc_s1_tag / alloc_s2_tag  in  3 each  producing ROB index when not ready.
- cdb_valid  in  1  result broadcast this cycle.
- cdb_tag  in  3  ROB index of broadcast result.
- cdb_data  in  DATA_W  broadcast result (low DATA_W bits).
- exec_ready  in  1  execution unit accepts an op this cycle.
- exec_done  in  1  execution unit finished the op in entry done_index.
- done_index  in  3  entry to release.
- flush  in  1  synchronous squash of all entries.
- exec_b  out  1  dispatch strobe to execution unit.
- rs_index  out  3  entry being dispatched.
- rs1_data / rs2_data  out  DATA_W each  operand values.
- func  out  4  opcode.
- rob_ind  out  3  ROB index.
- rd  out  4  destination register.

Function
REQ-004 SHALL hold per entry: state (FREE, WAIT, READY, ISSUED), func, rd, rob, and per operand valid bit, tag, data.
REQ-005 SHALL assert alloc_ready iff at least one entry is FREE at the start of the cycle.
REQ-006 SHALL on alloc_valid && alloc_ready write the lowest-index FREE entry; state READY if both operands valid after bypass, else WAIT.
REQ-007 SHALL bypass at allocation: operand not ready whose tag equals cdb_tag while cdb_valid is captured as valid with cdb_data.
REQ-008 SHALL on cdb_valid compare cdb_tag against every invalid operand of every WAIT entry; matches capture cdb_data and set valid.
REQ-009 SHALL move a WAIT entry to READY the cycle after its last operand becomes valid; a READY entry is dispatch-eligible the cycle after it became READY (no same-cycle wakeup-to-dispatch).
REQ-010 SHALL select, when exec_ready=1, the lowest-index READY entry; select is not age-based.
REQ-011 SHALL on selection register exec_b=1 and rs_index, rs1_data, rs2_data, func, rob_ind, rd from that entry, and mark it ISSUED, all at the same edge.
REQ-012 SHALL pulse exec_b for exactly one cycle per dispatch; at most one dispatch per cycle; exec_b=0 when exec_ready=0 or no READY entry.
REQ-013 SHALL hold data outputs at their last dispatched values while exec_b=0.
REQ-014 SHALL on exec_done free entry done_index iff it is ISSUED; otherwise ignore exec_done; done_index >= NUM_RS ignored.
REQ-015 SHALL allow exec_done freeing and allocation in the same cycle; the freed entry becomes allocatable only the following cycle.
REQ-016 SHALL allow dispatch and exec_done of a different entry in the same cycle, both taking effect.
REQ-017 SHALL on flush set all entries FREE and exec_b=0 at the next edge; flush overrides same-cycle alloc, dispatch and CDB capture.
REQ-018 SHALL compare CDB tags on all 3 bits; a CDB tag matching no entry has no effect.

Reset
REQ-019 SHALL on rst_n=0 immediately set all entries FREE, all operand valid bits 0, exec_b=0, rs_index=0, rs1_data=0, rs2_data=0, func=0, rob_ind=0, rd=0.
REQ-020 SHALL ignore alloc_valid, cdb_valid and exec_done while rst_n=0; reset asserted mid-operation discards all entries including ISSUED ones.

Verification
REQ-021 Ready alloc: func=0000, rd=3, rob=1, s1=5, s2=7 both ready, exec_ready=1 -> exec_b pulses 2 edges later, rs_index=0, rs1_data=5, rs2_data=7, rob_ind=1, rd=3.
REQ-022 Wakeup: alloc s1 tag=2 not ready, s2=4; later cdb_valid, tag=2, data=9 -> entry dispatches with rs1_data=9, rs2_data=4 two cycles after the broadcast.
REQ-023 Full: three allocations without exec_done -> alloc_ready=0, fourth alloc_valid ignored; exec_done, done_index=1 -> alloc_ready=1 next cycle, next alloc lands in entry 1.
REQ-024 Bypass: alloc with s2 tag=4 while cdb_valid, tag=4, data=0x11 in same cycle -> entry READY, dispatches rs2_data=0x11.
REQ-025 Priority/backpressure: entries 0 and 2 READY, exec_ready=0 for 3 cycles -> no exec_b; exec_ready=1 -> entry 0 then entry 2 on consecutive cycles.
REQ-026 Flush/reset: entries WAIT and ISSUED, assert flush (then separately rst_n=0 mid-dispatch) -> exec_b=0, alloc_ready=1, all entries FREE, later CDB for old tags has no effect.
